io_port_ctrl: RTL and testbench
===============================

Name: io_port_ctrl

Overview:
- Responder side of the processor core IO bus. Services core input requests (req_in/addr_in → io_in) and output writes (out_en/addr_out/data_out).
- Bridges the core IO bus to NUIOIN input and NUIOOU output external channels. Each channel has a one-entry holding register and a valid/ready handshake.
- Sits between core_fx and the peripherals. The core cannot stall, so the block absorbs rate mismatch and reports lost or stale data through sticky flags.

Parameters:
- NUBITS, 32, data width (matches core)
- NUIOIN, 8, number of input channels (≥1)
- NUIOOU, 8, number of output channels (≥1)
- AWI, (NUIOIN>1)?$clog2(NUIOIN):1, input address width (derived, not overridden)
- AWO, (NUIOOU>1)?$clog2(NUIOOU):1, output address width (derived, not overridden)

Ports:
- clk  in  1  clock, single domain
- rst  in  1  reset, synchronous, active-high
- req_in  in  1  core input request; the channel is consumed at this edge
- addr_in  in  AWI  input channel selected by core
- io_in  out  NUBITS  data returned to core
- out_en  in  1  core output write strobe
- addr_out  in  AWO  output channel selected by core
- data_out  in  NUBITS  data written by core
- ext_in_data  in  NUIOIN*NUBITS  source data, channel k at bits [k*NUBITS +: NUBITS]
- ext_in_valid  in  NUIOIN  source valid per channel
- ext_in_ready  out  NUIOIN  block ready per input channel
- ext_out_data  out  NUIOOU*NUBITS  sink data, same packing as ext_in_data
- ext_out_valid  out  NUIOOU  sink valid per channel
- ext_out_ready  in  NUIOOU  sink ready per channel
- udf_flag  out  NUIOIN  sticky: core read an empty input channel
- ovf_flag  out  NUIOOU  sticky: core overwrote an unaccepted output
- flag_clr  in  1  clears all sticky flags

Behaviour:
- Reset (synchronous, rst=1 at edge) clears:
  - all input hold registers, in_full[k], output registers, ext_out_valid and both flag vectors, to 0
  - io_in = 0, ext_in_ready = all ones, ext_out_data = 0
  - rst overrides every other input, including mid-handshake; a pending output word is dropped.
- Input channel k (hold register H[k], bit in_full[k]):
  - ext_in_ready[k] = ~in_full[k] | (req_in & addr_in==k). This is a combinational path from req_in, deliberate and allowed.
  - Source transfer occurs when ext_in_valid[k] & ext_in_ready[k]: H[k] ← data and in_full[k] ← 1 at that edge.
  - io_in is combinational: H[addr_in] when addr_in<NUIOIN, else 0. The value is valid in the same cycle as req_in (zero-latency read).
  - Read with req_in & in_full[addr_in] → in_full cleared at the edge, unless a simultaneous source transfer on the same channel reloads it. In that case H takes the new word and in_full stays 1 (back-to-back, no bubble).
  - Read with req_in & ~in_full[addr_in] → io_in returns the stale H value (last word, or 0 after reset) and udf_flag[addr_in] is set. A simultaneous source transfer on that channel still loads H for the next read; the current read sees the old value.
  - addr_in ≥ NUIOIN → io_in = 0, no state change, no flag.
- Output channel j (register O[j], ext_out_valid[j]):
  - Sink transfer occurs when ext_out_valid[j] & ext_out_ready[j] → ext_out_valid[j] cleared.
  - out_en & addr_out==j → O[j] ← data_out and ext_out_valid[j] ← 1 at the edge. This takes priority over clearing by a simultaneous sink transfer.
  - ovf_flag[j] is set on out_en when ext_out_valid[j] & ~ext_out_ready[j] in that cycle (the unaccepted word is overwritten). Write with a same-cycle accept is not an overflow.
  - ext_out_data[j] = O[j] (registered, 1-cycle latency from out_en). O[j] holds stable while valid & ~ready.
  - addr_out ≥ NUIOOU → write ignored.
- Flags:
  - flag_clr clears both vectors.
  - A set event in the same cycle as flag_clr wins, so the flag ends at 1.
- NUIOIN=1 / NUIOOU=1: the address ports are 1 bit and ignored; channel 0 is always selected.
- req_in and out_en may be asserted in the same cycle; they are fully independent.

Test Plan:
- Reset: hold rst 2 cycles mid-traffic → ext_out_valid=0, ext_in_ready=all 1, io_in=0, flags=0.
- Input load/read: ch3 source drives 0x0000_00A5 with valid 1 cycle → ext_in_ready[3]=0 next cycle. Then req_in, addr_in=3 → io_in=0xA5 in that cycle, and ext_in_ready[3]=1 after the edge.
- Back-to-back input: in_full[2]=1 (0x11), source valid with 0x22, req_in addr 2 same cycle → io_in=0x11, H[2]=0x22, in_full[2] stays 1. Next read returns 0x22.
- Underflow: req_in addr 5 on an empty channel → io_in=stale value, udf_flag[5]=1. flag_clr → 0. Repeat with flag_clr in the same cycle → flag=1.
- Output backpressure: out_en ch1 with 0x1234 and ext_out_ready[1]=0 → ext_out_valid[1]=1 and data=0x1234 next cycle. Second out_en with 0x5678 while still not ready → data=0x5678 and ovf_flag[1]=1. ready=1 → valid clears.
- Write-on-accept: valid[4]=1, ready[4]=1, out_en ch4 with 0xBEEF same cycle → valid stays 1, data=0xBEEF, ovf_flag[4]=0. Also out_en addr_out=7 with NUIOOU=6 → no change.

Source files
------------

// File: rtl/io_port_ctrl_if.sv
// Core IO bus plus external input/output channel bundle for io_port_ctrl.
// The slave modport is the controller's view; master is the core/peripheral side.
interface io_port_ctrl_if #(
   parameter int NUBITS = 32,
   parameter int NUIOIN = 8,
   parameter int NUIOOU = 8
);
   localparam int AWI = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
   localparam int AWO = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

   logic                     req_in;
   logic [AWI-1:0]           addr_in;
   logic [NUBITS-1:0]        io_in;
   logic                     out_en;
   logic [AWO-1:0]           addr_out;
   logic [NUBITS-1:0]        data_out;
   logic [NUIOIN*NUBITS-1:0] ext_in_data;
   logic [NUIOIN-1:0]        ext_in_valid;
   logic [NUIOIN-1:0]        ext_in_ready;
   logic [NUIOOU*NUBITS-1:0] ext_out_data;
   logic [NUIOOU-1:0]        ext_out_valid;
   logic [NUIOOU-1:0]        ext_out_ready;
   logic [NUIOIN-1:0]        udf_flag;
   logic [NUIOOU-1:0]        ovf_flag;
   logic                     flag_clr;

   modport slave (
      input  req_in, addr_in, out_en, addr_out, data_out,
      input  ext_in_data, ext_in_valid, ext_out_ready, flag_clr,
      output io_in, ext_in_ready, ext_out_data, ext_out_valid, udf_flag, ovf_flag
   );

   modport master (
      output req_in, addr_in, out_en, addr_out, data_out,
      output ext_in_data, ext_in_valid, ext_out_ready, flag_clr,
      input  io_in, ext_in_ready, ext_out_data, ext_out_valid, udf_flag, ovf_flag
   );
endinterface

// File: rtl/io_port_ctrl.sv
// Responder for the core IO bus: one-entry hold registers per input/output channel,
// zero-latency core reads, and sticky underflow/overflow flags since the core never stalls.
module io_port_ctrl #(
   parameter int NUBITS = 32,
   parameter int NUIOIN = 8,
   parameter int NUIOOU = 8
) (
   input logic           clk,
   input logic           rst,
   io_port_ctrl_if.slave bus
);
   localparam int AWI = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
   localparam int AWO = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

   logic [NUIOIN-1:0][NUBITS-1:0] hold_q, hold_d;
   logic [NUIOIN-1:0]             full_q, full_d;
   logic [NUIOIN-1:0]             udf_q, udf_d;
   logic [NUIOOU-1:0][NUBITS-1:0] out_q, out_d;
   logic [NUIOOU-1:0]             vld_q, vld_d;
   logic [NUIOOU-1:0]             ovf_q, ovf_d;

   logic [NUIOIN-1:0] in_sel_s, rd_hit_s, in_ready_s, ld_s;
   logic [NUIOOU-1:0] wr_hit_s;
   logic [NUBITS-1:0] io_in_s;

   // Address decode; an out-of-range address selects no channel and reads as zero.
   always_comb begin
      in_sel_s   = '0;
      rd_hit_s   = '0;
      in_ready_s = '0;
      ld_s       = '0;
      wr_hit_s   = '0;
      io_in_s    = '0;
      for (int k = 0; k < NUIOIN; k++) begin
         if (NUIOIN == 1) begin
            in_sel_s[k] = 1'b1;
         end else if (bus.addr_in == AWI'(k)) begin
            in_sel_s[k] = 1'b1;
         end else begin
            in_sel_s[k] = 1'b0;
         end
         rd_hit_s[k]   = bus.req_in & in_sel_s[k];
         in_ready_s[k] = ~full_q[k] | rd_hit_s[k];
         ld_s[k]       = bus.ext_in_valid[k] & in_ready_s[k];
         if (in_sel_s[k]) begin
            io_in_s = hold_q[k];
         end else begin
            io_in_s = io_in_s;
         end
      end
      for (int j = 0; j < NUIOOU; j++) begin
         if (NUIOOU == 1) begin
            wr_hit_s[j] = bus.out_en;
         end else if (bus.addr_out == AWO'(j)) begin
            wr_hit_s[j] = bus.out_en;
         end else begin
            wr_hit_s[j] = 1'b0;
         end
      end
   end

   // Next state for channel registers and sticky flags (set beats clear).
   always_comb begin
      hold_d = hold_q;
      full_d = full_q;
      out_d  = out_q;
      vld_d  = vld_q;
      udf_d  = bus.flag_clr ? '0 : udf_q;
      ovf_d  = bus.flag_clr ? '0 : ovf_q;
      for (int k = 0; k < NUIOIN; k++) begin
         // A load on the read cycle refills the entry, so the read and reload merge.
         if (ld_s[k]) begin
            hold_d[k] = bus.ext_in_data[k*NUBITS +: NUBITS];
            full_d[k] = 1'b1;
         end else if (rd_hit_s[k]) begin
            full_d[k] = 1'b0;
         end else begin
            full_d[k] = full_q[k];
         end
         if (rd_hit_s[k] & ~full_q[k]) begin
            udf_d[k] = 1'b1;
         end else begin
            udf_d[k] = udf_d[k];
         end
      end
      for (int j = 0; j < NUIOOU; j++) begin
         if (wr_hit_s[j]) begin
            out_d[j] = bus.data_out;
            vld_d[j] = 1'b1;
            if (vld_q[j] & ~bus.ext_out_ready[j]) begin
               ovf_d[j] = 1'b1;
            end else begin
               ovf_d[j] = ovf_d[j];
            end
         end else if (vld_q[j] & bus.ext_out_ready[j]) begin
            vld_d[j] = 1'b0;
         end else begin
            vld_d[j] = vld_q[j];
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= '0;
         full_q <= '0;
         udf_q  <= '0;
         out_q  <= '0;
         vld_q  <= '0;
         ovf_q  <= '0;
      end else begin
         hold_q <= hold_d;
         full_q <= full_d;
         udf_q  <= udf_d;
         out_q  <= out_d;
         vld_q  <= vld_d;
         ovf_q  <= ovf_d;
      end
   end

   assign bus.io_in         = io_in_s;
   assign bus.ext_in_ready  = in_ready_s;
   assign bus.ext_out_data  = out_q;
   assign bus.ext_out_valid = vld_q;
   assign bus.udf_flag      = udf_q;
   assign bus.ovf_flag      = ovf_q;
endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl with 8 input and 6 output channels.
module tb_io_port_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [191:0] exp_od;

   io_port_ctrl_if #(.NUBITS(32), .NUIOIN(8), .NUIOOU(6)) bus ();

   io_port_ctrl #(.NUBITS(32), .NUIOIN(8), .NUIOOU(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst               = 1'b1;
      bus.req_in        = 1'b0;
      bus.addr_in       = 3'd0;
      bus.out_en        = 1'b0;
      bus.addr_out      = 3'd0;
      bus.data_out      = 32'h0;
      bus.ext_in_data   = '0;
      bus.ext_in_valid  = 8'h00;
      bus.ext_out_ready = 6'h00;
      bus.flag_clr      = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("init_ready", bus.ext_in_ready, 8'hFF);
      chk("init_valid", bus.ext_out_valid, 6'h00);
      chk("init_io_in", bus.io_in, 32'h0);
      chk("init_udf", bus.udf_flag, 8'h00);

      // traffic, then reset while it is still being driven
      bus.ext_in_data[0 +: 32] = 32'h77;
      bus.ext_in_valid = 8'h01;
      bus.out_en = 1'b1; bus.addr_out = 3'd0; bus.data_out = 32'h99;
      bus.req_in = 1'b1; bus.addr_in = 3'd5;
      tick();
      chk("mid_ready", bus.ext_in_ready, 8'hFE);
      chk("mid_valid", bus.ext_out_valid, 6'h01);
      chk("mid_udf", bus.udf_flag, 8'h20);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      bus.ext_in_valid = 8'h00; bus.out_en = 1'b0; bus.req_in = 1'b0; bus.addr_in = 3'd0;
      #1;
      chk("rst_valid", bus.ext_out_valid, 6'h00);
      chk("rst_ready", bus.ext_in_ready, 8'hFF);
      chk("rst_io_in", bus.io_in, 32'h0);
      chk("rst_udf", bus.udf_flag, 8'h00);
      chk("rst_ovf", bus.ovf_flag, 6'h00);
      chk("rst_odata", bus.ext_out_data, 192'h0);

      // input load and zero-latency read on ch3
      bus.ext_in_data[3*32 +: 32] = 32'h0000_00A5;
      bus.ext_in_valid = 8'h08;
      tick();
      bus.ext_in_valid = 8'h00;
      #1;
      chk("ld3_ready", bus.ext_in_ready, 8'hF7);
      bus.req_in = 1'b1; bus.addr_in = 3'd3;
      #1;
      chk("rd3_io_in", bus.io_in, 32'hA5);
      chk("rd3_ready_comb", bus.ext_in_ready, 8'hFF);
      tick();
      bus.req_in = 1'b0;
      #1;
      chk("rd3_ready_after", bus.ext_in_ready, 8'hFF);
      chk("rd3_udf", bus.udf_flag, 8'h00);

      // back-to-back on ch2
      bus.ext_in_data[2*32 +: 32] = 32'h11;
      bus.ext_in_valid = 8'h04;
      tick();
      bus.ext_in_data[2*32 +: 32] = 32'h22;
      bus.req_in = 1'b1; bus.addr_in = 3'd2;
      #1;
      chk("b2b_io_in", bus.io_in, 32'h11);
      chk("b2b_ready", bus.ext_in_ready, 8'hFF);
      tick();
      bus.ext_in_valid = 8'h00; bus.req_in = 1'b0;
      #1;
      chk("b2b_full", bus.ext_in_ready, 8'hFB);
      bus.req_in = 1'b1;
      #1;
      chk("b2b_io_in2", bus.io_in, 32'h22);
      tick();
      bus.req_in = 1'b0;
      #1;
      chk("b2b_empty", bus.ext_in_ready, 8'hFF);
      chk("b2b_udf", bus.udf_flag, 8'h00);

      // underflow on ch5 and stale read on ch3
      bus.req_in = 1'b1; bus.addr_in = 3'd5;
      #1;
      chk("udf5_io_in", bus.io_in, 32'h0);
      tick();
      bus.req_in = 1'b0;
      #1;
      chk("udf5_flag", bus.udf_flag, 8'h20);
      bus.flag_clr = 1'b1;
      tick();
      bus.flag_clr = 1'b0;
      #1;
      chk("udf_clr", bus.udf_flag, 8'h00);
      bus.req_in = 1'b1; bus.flag_clr = 1'b1;
      tick();
      bus.req_in = 1'b0; bus.flag_clr = 1'b0;
      #1;
      chk("udf_set_wins", bus.udf_flag, 8'h20);
      bus.req_in = 1'b1; bus.addr_in = 3'd3;
      #1;
      chk("udf3_stale", bus.io_in, 32'hA5);
      tick();
      bus.req_in = 1'b0;
      #1;
      chk("udf3_flag", bus.udf_flag, 8'h28);
      bus.flag_clr = 1'b1;
      tick();
      bus.flag_clr = 1'b0;

      // output backpressure on ch1
      bus.out_en = 1'b1; bus.addr_out = 3'd1; bus.data_out = 32'h1234;
      tick();
      bus.out_en = 1'b0;
      #1;
      chk("o1_valid", bus.ext_out_valid, 6'h02);
      chk("o1_data", bus.ext_out_data[32 +: 32], 32'h1234);
      chk("o1_ovf0", bus.ovf_flag, 6'h00);
      bus.out_en = 1'b1; bus.data_out = 32'h5678;
      tick();
      bus.out_en = 1'b0;
      #1;
      chk("o1_data2", bus.ext_out_data[32 +: 32], 32'h5678);
      chk("o1_ovf", bus.ovf_flag, 6'h02);
      chk("o1_valid2", bus.ext_out_valid, 6'h02);
      bus.ext_out_ready = 6'h02;
      tick();
      bus.ext_out_ready = 6'h00;
      #1;
      chk("o1_accept", bus.ext_out_valid, 6'h00);
      chk("o1_data_hold", bus.ext_out_data[32 +: 32], 32'h5678);

      // write on the accept cycle of ch4
      bus.out_en = 1'b1; bus.addr_out = 3'd4; bus.data_out = 32'hAAAA;
      tick();
      bus.ext_out_ready = 6'h10; bus.data_out = 32'hBEEF;
      tick();
      bus.out_en = 1'b0;
      #1;
      chk("o4_valid", bus.ext_out_valid, 6'h10);
      chk("o4_data", bus.ext_out_data[4*32 +: 32], 32'hBEEF);
      chk("o4_ovf", bus.ovf_flag, 6'h02);
      tick();
      bus.ext_out_ready = 6'h00;
      #1;
      chk("o4_drain", bus.ext_out_valid, 6'h00);
      bus.out_en = 1'b1; bus.addr_out = 3'd7; bus.data_out = 32'hDEAD;
      tick();
      bus.out_en = 1'b0;
      #1;
      exp_od = '0;
      exp_od[32 +: 32]  = 32'h5678;
      exp_od[128 +: 32] = 32'hBEEF;
      chk("o7_valid", bus.ext_out_valid, 6'h00);
      chk("o7_data", bus.ext_out_data, exp_od);

      // overflow set wins over a same-cycle clear
      bus.out_en = 1'b1; bus.addr_out = 3'd0; bus.data_out = 32'h1;
      tick();
      bus.data_out = 32'h2; bus.flag_clr = 1'b1;
      tick();
      bus.out_en = 1'b0; bus.flag_clr = 1'b0;
      #1;
      chk("ovf_set_wins", bus.ovf_flag, 6'h01);
      chk("o0_data", bus.ext_out_data[0 +: 32], 32'h2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
